// File: rtl/salsa_core_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | salsa_core_arbiter_if : lane-side and core-side signals of the arbiter   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface salsa_core_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 512
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        done;
  logic [N_REQ-1:0]        err;
  logic [DATA_W-1:0]       result_data;
  logic                    busy;
  logic                    core_init;
  logic [DATA_W-1:0]       core_din;
  logic                    core_valid;
  logic [DATA_W-1:0]       core_dout;

  modport slave (
    input  req, req_data, core_valid, core_dout,
    output gnt, done, err, result_data, busy, core_init, core_din
  );

  modport master (
    output req, req_data, core_valid, core_dout,
    input  gnt, done, err, result_data, busy, core_init, core_din
  );
endinterface
`default_nettype wire

// File: rtl/salsa_core_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | salsa_core_arbiter : round-robin sharing of one salsa_20_8 core          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module salsa_core_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 512,
  parameter int TIMEOUT = 32
) (
  input  wire logic            clk,
  input  wire logic            reset,
  salsa_core_arbiter_if.slave  bus_if
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    win_q, win_d;
  logic [IDX_W-1:0]    rr_q, rr_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [N_REQ-1:0]    done_q, done_d;
  logic [N_REQ-1:0]    err_q, err_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic                init_q, init_d;
  logic                busy_q, busy_d;

  logic                pick_found;
  logic [IDX_W-1:0]    pick_idx;

  // Scan lanes starting at rr_q and wrapping; the first requester wins.
  always_comb begin
    logic [IDX_W:0] cand;
    pick_found = 1'b0;
    pick_idx   = rr_q;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N_REQ)) begin
        cand = cand - (IDX_W+1)'(N_REQ);
      end
      if (!pick_found && bus_if.req[cand[IDX_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    win_d    = win_q;
    rr_d     = rr_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    err_d    = '0;
    result_d = result_q;
    din_d    = din_q;
    init_d   = init_q;
    busy_d   = busy_q;

    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          win_d           = pick_idx;
          din_d           = bus_if.req_data[pick_idx*DATA_W +: DATA_W];
          init_d          = 1'b1;
          cnt_d           = '0;
          busy_d          = 1'b1;
          state_d         = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        // A valid arriving on the timeout cycle still counts as success.
        if (bus_if.core_valid) begin
          result_d = bus_if.core_dout;
          done_d   = gnt_q;
          init_d   = 1'b0;
          state_d  = S_RELEASE;
        end else if (cnt_q == CNT_W'(TIMEOUT-1)) begin
          err_d    = gnt_q;
          init_d   = 1'b0;
          state_d  = S_RELEASE;
        end
      end
      S_RELEASE: begin
        init_d = 1'b0;
        if (!bus_if.core_valid) begin
          gnt_d   = '0;
          busy_d  = 1'b0;
          rr_d    = (win_q == IDX_W'(N_REQ-1)) ? '0 : win_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        init_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      win_q    <= '0;
      rr_q     <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= '0;
      result_q <= '0;
      din_q    <= '0;
      init_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      win_q    <= win_d;
      rr_q     <= rr_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
      din_q    <= din_d;
      init_q   <= init_d;
      busy_q   <= busy_d;
    end
  end

  assign bus_if.gnt         = gnt_q;
  assign bus_if.done        = done_q;
  assign bus_if.err         = err_q;
  assign bus_if.result_data = result_q;
  assign bus_if.busy        = busy_q;
  assign bus_if.core_init   = init_q;
  assign bus_if.core_din    = din_q;

endmodule
`default_nettype wire

// File: tb/tb_salsa_core_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_salsa_core_arbiter : vector table, corner sequences, random jobs      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_salsa_core_arbiter;

  localparam int N       = 4;
  localparam int W       = 512;
  localparam int TIMEOUT = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  salsa_core_arbiter_if #(.N_REQ(N), .DATA_W(W)) bus ();

  salsa_core_arbiter #(.N_REQ(N), .DATA_W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_if (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] lane_data [N];
  always_comb begin
    for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = lane_data[i];
  end

  // Core stand-in: valid core_lat cycles after init rises, drops once init falls.
  int  core_lat    = 8;
  bit  core_never  = 1'b0;
  bit  force_valid = 1'b0;
  int  ccnt;

  function automatic logic [W-1:0] mix(input logic [W-1:0] d);
    return {d[W-2:0], d[W-1]} ^ {16{32'h9E3779B9}};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset)                ccnt <= 0;
    else if (!bus.core_init)  ccnt <= 0;
    else if (ccnt < core_lat) ccnt <= ccnt + 1;
  end
  assign bus.core_valid = force_valid | (!core_never && ccnt != 0 && ccnt == core_lat);
  assign bus.core_dout  = mix(bus.core_din);

  int           rr_model    = 0;
  logic [W-1:0] last_result = '0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expired(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic logic [W-1:0] rand512();
    logic [W-1:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic int pick(input logic [N-1:0] m, input int rr);
    for (int k = 0; k < N; k++) if (m[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.busy !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) expired(name);
  endtask

  // One complete job from IDLE; checks grant, latch, completion and release timing.
  task automatic do_job(input logic [N-1:0] mask, input int lat, input bit never,
                        input int exp_w, input bit mutate);
    logic [W-1:0] orig;
    int t0, n;
    wait_idle("pre_idle");
    core_lat   = lat;
    core_never = never;
    orig       = lane_data[exp_w];
    @(negedge clk);
    bus.req = mask;
    t0 = cyc;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.gnt == '0 && n < 5);
    if (bus.gnt == '0) expired("grant");
    chk("gnt", W'(bus.gnt), W'(1 << exp_w));
    chk("grant_lat", W'(cyc - t0), W'(1));
    chk("core_din", bus.core_din, orig);
    chk("core_init_on", W'(bus.core_init), W'(1));
    chk("busy_on", W'(bus.busy), W'(1));
    if (mutate) begin
      repeat (3) @(negedge clk);
      bus.req[exp_w]   = 1'b0;
      lane_data[exp_w] = ~lane_data[exp_w];
      @(negedge clk);
      chk("din_stable", bus.core_din, orig);
    end
    n = 0;
    while ((bus.done | bus.err) == '0 && n < TIMEOUT + 10) begin @(negedge clk); n++; end
    if ((bus.done | bus.err) == '0) expired("completion");
    chk("done", W'(bus.done), never ? W'(0) : W'(1 << exp_w));
    chk("err",  W'(bus.err),  never ? W'(1 << exp_w) : W'(0));
    chk("done_lat", W'(cyc - t0), never ? W'(TIMEOUT + 1) : W'(lat + 2));
    if (!never) last_result = mix(orig);
    chk("result", bus.result_data, last_result);
    chk("core_init_off", W'(bus.core_init), W'(0));
    @(negedge clk);
    chk("pulse_once", W'(bus.done | bus.err), W'(0));
    bus.req = '0;
    n = 0;
    while (bus.busy !== 1'b0 && n < 10) begin @(negedge clk); n++; end
    if (bus.busy !== 1'b0) expired("release");
    chk("idle_lat", W'(cyc - t0), never ? W'(TIMEOUT + 2) : W'(lat + 4));
    chk("gnt_off", W'(bus.gnt), W'(0));
    rr_model = (exp_w + 1) % N;
  endtask

  typedef struct {
    logic [N-1:0] mask;
    int           lat;
    bit           never;
    int           exp_w;
    bit           mutate;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int prev, w, n;
    logic [N-1:0] m;

    vecs[0] = '{4'b0100,  8, 1'b0, 2, 1'b0};
    vecs[1] = '{4'b1000,  8, 1'b0, 3, 1'b0};
    vecs[2] = '{4'b1001,  8, 1'b0, 0, 1'b0};
    vecs[3] = '{4'b1000, 31, 1'b0, 3, 1'b0};
    vecs[4] = '{4'b1111,  8, 1'b1, 0, 1'b0};
    vecs[5] = '{4'b0001,  8, 1'b0, 0, 1'b1};
    vecs[6] = '{4'b0110,  1, 1'b0, 1, 1'b0};
    vecs[7] = '{4'b0011,  8, 1'b0, 0, 1'b0};
    vecs[8] = '{4'b1010,  8, 1'b0, 1, 1'b0};
    vecs[9] = '{4'b1010,  8, 1'b0, 3, 1'b0};

    for (int i = 0; i < N; i++) lane_data[i] = rand512();
    lane_data[2] = {64{8'hA5}};
    bus.req = '0;
    reset   = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_gnt",    W'(bus.gnt),       W'(0));
    chk("rst_done",   W'(bus.done),      W'(0));
    chk("rst_err",    W'(bus.err),       W'(0));
    chk("rst_busy",   W'(bus.busy),      W'(0));
    chk("rst_init",   W'(bus.core_init), W'(0));
    chk("rst_din",    bus.core_din,      '0);
    chk("rst_result", bus.result_data,   '0);

    for (int i = 0; i < 10; i++) begin
      do_job(vecs[i].mask, vecs[i].lat, vecs[i].never, vecs[i].exp_w, vecs[i].mutate);
      for (int j = 0; j < N; j++) lane_data[j] = rand512();
    end

    // All lanes held: service rotates with a fixed 12-cycle job period.
    core_lat = 8; core_never = 1'b0;
    @(negedge clk);
    bus.req = '1;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      w = pick(4'b1111, rr_model);
      n = 0;
      while (bus.done == '0 && n < 30) begin @(negedge clk); n++; end
      if (bus.done == '0) expired("rr_done");
      chk("rr_lane", W'(bus.done), W'(1 << w));
      chk("rr_result", bus.result_data, mix(lane_data[w]));
      if (k > 0) chk("rr_period", W'(cyc - prev), W'(12));
      prev = cyc;
      rr_model = (w + 1) % N;
      @(negedge clk);
    end
    bus.req = '0;
    wait_idle("rr_idle");

    // Stale valid while idle must not start or finish anything.
    force_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stale_busy", W'(bus.busy), W'(0));
      chk("stale_done", W'(bus.done | bus.gnt), W'(0));
    end
    force_valid = 1'b0;
    @(negedge clk);

    // Reset during RUN aborts at once and clears the rotation pointer.
    core_lat = 8;
    bus.req = 4'b0100;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.gnt == '0 && n < 5);
    if (bus.gnt == '0) expired("rst_run_grant");
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_gnt",  W'(bus.gnt),       W'(0));
    chk("arst_init", W'(bus.core_init), W'(0));
    chk("arst_busy", W'(bus.busy),      W'(0));
    chk("arst_pulse", W'(bus.done | bus.err), W'(0));
    bus.req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rr_model    = 0;
    last_result = '0;
    do_job(4'b1001, 8, 1'b0, 0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      for (int j = 0; j < N; j++) lane_data[j] = rand512();
      m = N'($urandom_range(1, (1 << N) - 1));
      w = pick(m, rr_model);
      if ($urandom_range(0, 7) == 0) do_job(m, 8, 1'b1, w, 1'b0);
      else begin
        n = $urandom_range(1, 20);
        do_job(m, n, 1'b0, w, (n >= 6) && ($urandom_range(0, 1) == 1));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
